// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractcam rule-update path.
package fractcam_pkg;

    // Update request opcode.
    typedef enum logic {
        OP_WRITE  = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    // Entries per SRL block and bits needed to select one of them.
    localparam int unsigned SLOT_W            = 3;
    localparam int unsigned SLOTS             = 8;

    // Default enable hold per pass: 256 shift cycles plus 32 write cycles.
    localparam int unsigned UPDATE_CYCLES_DEF = 288;

    // Update scheduler FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/tcam_shadow_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module tcam_shadow_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned WIDTH = 640
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write and registered read; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tcam_update_sched.sv
// Sequences single-entry rule updates into the fractcam SRL update datapath.
module tcam_update_sched
    import fractcam_pkg::*;
#(
    parameter int unsigned TCAM_WIDTH        = 40,
    parameter int unsigned SLICEM_ADDR_WIDTH = 2,
    parameter int unsigned TCAM_DEPTH        = 32,
    parameter int unsigned UPDATE_CYCLES     = UPDATE_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_op,
    input  logic [SLICEM_ADDR_WIDTH+2:0]  req_addr,
    input  logic [TCAM_WIDTH-1:0]         req_data,
    input  logic [TCAM_WIDTH-1:0]         req_keep,
    output logic [TCAM_WIDTH*8-1:0]       upd_data,
    output logic [TCAM_WIDTH*8-1:0]       upd_keep,
    output logic                          upd_enable,
    output logic [SLICEM_ADDR_WIDTH-1:0]  upd_enable_sel,
    input  logic                          upd_busy,
    output logic                          search_stall,
    output logic [TCAM_DEPTH-1:0]         entry_valid,
    output logic                          done
);

    localparam int unsigned ADDR_WIDTH = SLICEM_ADDR_WIDTH + 3;
    localparam int unsigned BLOCKS     = 2 ** SLICEM_ADDR_WIDTH;
    localparam int unsigned BLK_W      = TCAM_WIDTH * SLOTS;
    localparam int unsigned WORD_W     = 2 * BLK_W;
    localparam int unsigned CNT_W      = $clog2(UPDATE_CYCLES + 1);

    state_e                        state_q;
    state_e                        state_d;
    logic [CNT_W-1:0]              cnt_q;
    logic                          armed_q;
    op_e                           op_q;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [TCAM_WIDTH-1:0]         data_q;
    logic [TCAM_WIDTH-1:0]         keep_q;

    logic                          accept_c;
    logic                          merge_c;
    logic                          drain_exit_c;
    logic [WORD_W-1:0]             rd_word;
    logic [BLK_W-1:0]              merged_data;
    logic [BLK_W-1:0]              merged_keep;
    logic [SLOT_W-1:0]             slot;
    logic [SLICEM_ADDR_WIDTH-1:0]  blk;
    logic [SLICEM_ADDR_WIDTH-1:0]  req_blk;
    int unsigned                   slot_lsb;

    assign slot     = addr_q[SLOT_W-1:0];
    assign blk      = addr_q[ADDR_WIDTH-1:SLOT_W];
    assign req_blk  = req_addr[ADDR_WIDTH-1:SLOT_W];
    assign slot_lsb = 32'(slot) * TCAM_WIDTH;

    // Block-wide shadow of data (low half) and keep (high half).
    tcam_shadow_ram #(
        .DEPTH (BLOCKS),
        .AW    (SLICEM_ADDR_WIDTH),
        .WIDTH (WORD_W)
    ) u_shadow (
        .clk     (clk),
        .wr_en   (merge_c),
        .wr_addr (blk),
        .wr_data ({merged_keep, merged_data}),
        .rd_en   (accept_c),
        .rd_addr (req_blk),
        .rd_data (rd_word)
    );

    // Handshake and completion strobes; ready is held low for the cycle after reset.
    always_comb begin
        req_ready    = (state_q == ST_IDLE) && armed_q && !upd_busy;
        accept_c     = req_valid && req_ready;
        merge_c      = (state_q == ST_MERGE);
        drain_exit_c = (state_q == ST_DRAIN) && !upd_busy;
        done         = drain_exit_c;
    end

    // Replace the target slot inside the block read back from the shadow.
    always_comb begin
        merged_data = rd_word[BLK_W-1:0];
        merged_keep = rd_word[WORD_W-1:BLK_W];
        if (op_q == OP_WRITE) begin
            merged_data[slot_lsb +: TCAM_WIDTH] = data_q;
            merged_keep[slot_lsb +: TCAM_WIDTH] = keep_q;
        end else begin
            merged_data[slot_lsb +: TCAM_WIDTH] = '0;
            merged_keep[slot_lsb +: TCAM_WIDTH] = '1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_MERGE;
            end
            ST_MERGE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(UPDATE_CYCLES - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_exit_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, pass counter, datapath drive and valid-mask maintenance.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            op_q           <= OP_WRITE;
            addr_q         <= '0;
            data_q         <= '0;
            keep_q         <= '0;
            upd_data       <= '0;
            upd_keep       <= '0;
            upd_enable     <= 1'b0;
            upd_enable_sel <= '0;
            search_stall   <= 1'b0;
            entry_valid    <= '0;
        end else begin
            armed_q <= 1'b1;

            if (accept_c) begin
                op_q   <= op_e'(req_op);
                addr_q <= req_addr;
                data_q <= req_data;
                keep_q <= req_keep;
            end

            if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            // A stale rule must not hit while its block is being rewritten.
            if (merge_c) begin
                upd_data            <= merged_data;
                upd_keep            <= merged_keep;
                upd_enable_sel      <= blk;
                entry_valid[addr_q] <= 1'b0;
            end

            if (drain_exit_c && (op_q == OP_WRITE)) begin
                entry_valid[addr_q] <= 1'b1;
            end

            // Enable tracks RUN without gaps; stall covers RUN and DRAIN.
            upd_enable   <= (state_d == ST_RUN);
            search_stall <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
        end
    end

endmodule

// File: tb/tb_tcam_update_sched.sv
// Scoreboard bench for tcam_update_sched: stimulus pushes expected passes, monitor checks them.
module tb_tcam_update_sched;

    localparam int unsigned TW  = 40;
    localparam int unsigned BW  = TW * 8;
    localparam int unsigned DEP = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [4:0]    req_addr;
    logic [TW-1:0] req_data;
    logic [TW-1:0] req_keep;
    logic [BW-1:0] upd_data;
    logic [BW-1:0] upd_keep;
    logic          upd_enable;
    logic [1:0]    upd_enable_sel;
    logic          upd_busy;
    logic          search_stall;
    logic [DEP-1:0] entry_valid;
    logic          done;

    tcam_update_sched dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_keep       (req_keep),
        .upd_data       (upd_data),
        .upd_keep       (upd_keep),
        .upd_enable     (upd_enable),
        .upd_enable_sel (upd_enable_sel),
        .upd_busy       (upd_busy),
        .search_stall   (search_stall),
        .entry_valid    (entry_valid),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     sel;
        logic [BW-1:0]  data;
        logic [BW-1:0]  keep;
        logic [BW-1:0]  mask;
        logic [DEP-1:0] vdur;
        logic [DEP-1:0] vaft;
        int             gap;
        bit             abort;
    } exp_t;

    exp_t           sb[$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             passes = 0;

    logic [TW-1:0]  md [DEP];
    logic [TW-1:0]  mk [DEP];
    bit             known [DEP];
    logic [DEP-1:0] mvalid = '0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Update the reference shadow/valid model and queue the pass it implies.
    task automatic push_req(input bit op, input int addr, input logic [TW-1:0] d,
                            input logic [TW-1:0] k, input int gap, input bit abort);
        exp_t e;
        int   blk;
        blk = addr / 8;
        if (op == 1'b0) begin
            md[addr] = d;
            mk[addr] = k;
        end else begin
            md[addr] = '0;
            mk[addr] = '1;
        end
        known[addr] = 1'b1;
        e.sel  = 2'(blk);
        e.data = '0;
        e.keep = '0;
        e.mask = '0;
        for (int s = 0; s < 8; s++) begin
            if (known[blk*8+s]) begin
                e.data[s*TW +: TW] = md[blk*8+s];
                e.keep[s*TW +: TW] = mk[blk*8+s];
                e.mask[s*TW +: TW] = '1;
            end
        end
        e.vdur = mvalid & ~(32'd1 << addr);
        if (abort)
            e.vaft = '0;
        else if (op == 1'b0)
            e.vaft = e.vdur | (32'd1 << addr);
        else
            e.vaft = e.vdur;
        mvalid  = e.vaft;
        e.gap   = gap;
        e.abort = abort;
        sb.push_back(e);
    endtask

    task automatic do_req(input bit op, input logic [4:0] addr, input logic [TW-1:0] d,
                          input logic [TW-1:0] k);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = d;
        req_keep  = k;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: got no req_ready want req_ready=1");
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pass(input int target);
        int t;
        t = 0;
        while (passes < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (passes < target) begin
            n_cmp++; n_err++;
            $display("FAIL pass_timeout: got %0d passes want %0d", passes, target);
        end
    endtask

    task automatic wait_enable(input logic lvl);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (upd_enable !== lvl && t < 2000);
        if (upd_enable !== lvl) begin
            n_cmp++; n_err++;
            $display("FAIL enable_wait: got %0b want %0b", upd_enable, lvl);
        end
    endtask

    // Monitor: each enable burst pops one expected pass and checks it end to end.
    initial begin : monitor
        exp_t          e;
        int            len;
        int            gap;
        bit            rdy_seen;
        bit            unstable;
        bit            stall_gap;
        bit            done_seen;
        logic [BW-1:0] d0;
        logic [BW-1:0] k0;
        logic [1:0]    s0;
        forever begin
            @(negedge clk);
            if (!rst && upd_enable === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_pass: got upd_enable=1 want no pass");
                    len = 0;
                    while (upd_enable === 1'b1 && len < 1000) begin
                        len++;
                        @(negedge clk);
                    end
                end else begin
                    e = sb.pop_front();
                    check("upd_enable_sel", BW'(upd_enable_sel), BW'(e.sel));
                    check("upd_data", upd_data & e.mask, e.data);
                    check("upd_keep", upd_keep & e.mask, e.keep);
                    check("entry_valid_during_run", BW'(entry_valid), BW'(e.vdur));
                    d0 = upd_data; k0 = upd_keep; s0 = upd_enable_sel;
                    len = 0; rdy_seen = 0; unstable = 0;
                    while (upd_enable === 1'b1 && len < 1000) begin
                        len++;
                        if (req_ready !== 1'b0) rdy_seen = 1;
                        if (upd_data !== d0 || upd_keep !== k0 || upd_enable_sel !== s0) unstable = 1;
                        @(negedge clk);
                    end
                    check("req_ready_during_pass", BW'(rdy_seen), BW'(0));
                    check("upd_hold_stable", BW'(unstable), BW'(0));
                    if (e.abort) begin
                        check("abort_enable_len", BW'(len), BW'(101));
                        check("abort_search_stall", BW'(search_stall), BW'(0));
                        check("abort_entry_valid", BW'(entry_valid), BW'(0));
                        done_seen = 0;
                        for (int i = 0; i < 10; i++) begin
                            if (done !== 1'b0) done_seen = 1;
                            @(negedge clk);
                        end
                        check("abort_no_done", BW'(done_seen), BW'(0));
                    end else begin
                        check("enable_len", BW'(len), BW'(288));
                        gap = 0; stall_gap = 0;
                        while (done !== 1'b1 && gap < 50) begin
                            if (search_stall !== 1'b1 || upd_enable !== 1'b0) stall_gap = 1;
                            gap++;
                            @(negedge clk);
                        end
                        check("drain_to_done", BW'(gap), BW'(e.gap));
                        check("drain_stall", BW'(stall_gap), BW'(0));
                        @(negedge clk);
                        check("entry_valid_after", BW'(entry_valid), BW'(e.vaft));
                    end
                    passes++;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < DEP; i++) begin
            known[i] = 1'b0;
            md[i] = '0;
            mk[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
        req_data = '0; req_keep = '0; upd_busy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", BW'(req_ready), BW'(0));
        check("rst_upd_enable", BW'(upd_enable), BW'(0));
        check("rst_search_stall", BW'(search_stall), BW'(0));
        check("rst_entry_valid", BW'(entry_valid), BW'(0));
        check("rst_done", BW'(done), BW'(0));
        check("rst_upd_data", upd_data, BW'(0));
        check("rst_upd_keep", upd_keep, BW'(0));
        check("rst_upd_sel", BW'(upd_enable_sel), BW'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write into block 0, slot 5.
        push_req(1'b0, 5, 40'h12_3456_789A, '1, 0, 1'b0);
        do_req(1'b0, 5'd5, 40'h12_3456_789A, '1);
        wait_pass(1);

        // Back-to-back writes into block 1; second pass carries both.
        push_req(1'b0, 9, 40'hAA_0000_0009, 40'hFF_FFFF_FF00, 0, 1'b0);
        do_req(1'b0, 5'd9, 40'hAA_0000_0009, 40'hFF_FFFF_FF00);
        push_req(1'b0, 10, 40'hBB_0000_000A, 40'h0F_FFFF_FFFF, 0, 1'b0);
        do_req(1'b0, 5'd10, 40'hBB_0000_000A, 40'h0F_FFFF_FFFF);
        wait_pass(3);

        // Rewrite then delete entry 9.
        push_req(1'b0, 9, 40'hCC_1234_5678, '1, 0, 1'b0);
        do_req(1'b0, 5'd9, 40'hCC_1234_5678, '1);
        wait_pass(4);
        push_req(1'b1, 9, '0, '0, 0, 1'b0);
        do_req(1'b1, 5'd9, 40'hDE_ADBE_EF00, 40'h00_0000_0001);
        wait_pass(5);

        // Datapath busy for three cycles after the pass: DRAIN stretches.
        push_req(1'b0, 20, 40'h55_AA55_AA55, 40'hF0_F0F0_F0F0, 3, 1'b0);
        do_req(1'b0, 5'd20, 40'h55_AA55_AA55, 40'hF0_F0F0_F0F0);
        upd_busy = 1'b1;
        wait_enable(1'b1);
        wait_enable(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        upd_busy = 1'b0;
        wait_pass(6);

        // Reset at RUN cycle 100 abandons the pass.
        push_req(1'b0, 28, 40'h01_0203_0405, '1, 0, 1'b1);
        do_req(1'b0, 5'd28, 40'h01_0203_0405, '1);
        wait_enable(1'b1);
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_pass(7);

        // A fresh request after the reset completes normally.
        push_req(1'b0, 28, 40'h77_6655_4433, 40'h3F_FFFF_FFFC, 0, 1'b0);
        do_req(1'b0, 5'd28, 40'h77_6655_4433, 40'h3F_FFFF_FFFC);
        wait_pass(8);

        // Busy in IDLE blocks acceptance until it drops.
        push_req(1'b0, 3, 40'h99_8877_6655, '1, 0, 1'b0);
        @(posedge clk); #1;
        upd_busy  = 1'b1;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_addr  = 5'd3;
        req_data  = 40'h99_8877_6655;
        req_keep  = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy_ready", BW'(req_ready), BW'(0));
        end
        @(posedge clk); #1;
        upd_busy = 1'b0;
        @(negedge clk);
        check("idle_unbusy_ready", BW'(req_ready), BW'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_pass(9);

        repeat (3) @(negedge clk);
        check("queue_drained", BW'(sb.size()), BW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tcam_update_sched.md
Name: tcam_update_sched

Overview:
- Sequences rule updates into the fractcam SRL update datapath.
- Accepts single-entry write/delete requests over a valid/ready handshake.
- Keeps a block-wide shadow copy of all entries (data+keep), read-modify-writes the 8-entry block containing the target, drives the update datapath's 8-entry inputs, enable and block select for a full update pass, and stalls search while the pass runs.
- Maintains the per-entry valid mask used by the downstream match priority encoder.

Parameters:
- TCAM_WIDTH, 40, key width in bits; multiple of 5.
- SLICEM_ADDR_WIDTH, 2, block index width; blocks = 2**SLICEM_ADDR_WIDTH.
- TCAM_DEPTH, 32, entries; must equal 8*2**SLICEM_ADDR_WIDTH.
- UPDATE_CYCLES, 288, cycles the update enable is held per pass (256 shift + 32 write).
- Derived localparam ADDR_WIDTH = SLICEM_ADDR_WIDTH+3.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  1  0=write entry, 1=delete entry
- req_addr  in  ADDR_WIDTH  entry index; [2:0]=slot in block, [ADDR_WIDTH-1:3]=block
- req_data  in  TCAM_WIDTH  rule value
- req_keep  in  TCAM_WIDTH  care mask (1=compare bit)
- upd_data  out  TCAM_WIDTH*8  block data, slot s at bits [s*TCAM_WIDTH +: TCAM_WIDTH]
- upd_keep  out  TCAM_WIDTH*8  block keep, same packing
- upd_enable  out  1  update enable to datapath
- upd_enable_sel  out  SLICEM_ADDR_WIDTH  block being rewritten
- upd_busy  in  1  datapath busy
- search_stall  out  1  search key ignored by datapath; lookups invalid
- entry_valid  out  TCAM_DEPTH  per-entry valid mask
- done  out  1  one-cycle pulse, update complete

Behaviour:
- Clock clk; reset rst synchronous, active-high.
- Reset values: req_ready=0, upd_enable=0, upd_enable_sel=0, upd_data=0, upd_keep=0, search_stall=0, entry_valid=0, done=0, FSM=IDLE, cycle counter=0.
- Shadow RAM contents are not cleared by reset. A reset block's invalid entries are masked by entry_valid.
- Shadow RAM: 2**SLICEM_ADDR_WIDTH words × 16*TCAM_WIDTH bits (8 data + 8 keep). Synchronous read, 1-cycle latency. Write-first is not relied on.
- FSM states and transitions:
  - IDLE: req_ready = ~upd_busy. On accept, latch op/addr/data/keep, issue shadow read of block -> READ.
  - READ: 1 cycle, read data returns -> MERGE.
  - MERGE: replace target slot.
    - Write: req data/keep.
    - Delete: data=0, keep=all ones.
    - Write merged word back to shadow; load upd_data/upd_keep/upd_enable_sel registers.
    - Clear entry_valid[addr] (write and delete alike, so stale rule cannot hit).
    - Go to RUN.
  - RUN: upd_enable=1 and search_stall=1 for exactly UPDATE_CYCLES consecutive cycles. Counter 0..UPDATE_CYCLES-1. upd_data/keep/sel held stable throughout.
  - DRAIN: upd_enable=0, search_stall=1. Stay until upd_busy=0, minimum 1 cycle.
    - On exit: set entry_valid[addr] if op=write, pulse done, go to IDLE.
- Latency: accept at cycle T -> upd_enable first high T+3 -> last high T+2+UPDATE_CYCLES -> done at T+3+UPDATE_CYCLES (upd_busy already low).
- req_ready is 0 in every state except IDLE. The next request can be accepted the cycle after done.
- upd_enable is never deasserted mid-pass; a gap would restart the datapath counters.
- Requests to the same block back-to-back: second sees the first's merged shadow word, because the write-back completes in MERGE before the next READ.
- upd_busy high in IDLE (datapath held by other logic): no accept until it drops.
- Reset mid-RUN: upd_enable and search_stall drop the next cycle. FSM to IDLE, entry_valid=0. The partial pass is abandoned with no done.
- req_addr ≥ TCAM_DEPTH is impossible by width; no range check.

Decomposition:
- Shared package (fractcam_pkg): op encodings (OP_WRITE=0, OP_DELETE=1), UPDATE_CYCLES default, FSM state encoding, slot width 3.
- One sub-module: tcam_shadow_ram, a simple dual-port sync-read RAM parameterised on depth/width, inferred as BRAM/LUTRAM.

Test Plan:
- Reset, then write addr=5 data=0x12_3456_789A keep=all ones -> upd_enable_sel=0; upd_data slot5=0x123456789A, other slots 0/keep all ones; upd_enable high exactly 288 cycles; done at T+291; entry_valid=0x20.
- Write addr=9, then addr=10 back-to-back -> second pass sel=1 carries both slot1 and slot2 values; req_ready=0 for the whole first pass; entry_valid bits 9,10 set.
- Write addr=9 then delete addr=9 -> entry_valid[9] clears at MERGE of the delete and stays 0 after done; slot1 keep=all ones, data=0.
- Hold upd_busy=1 for 3 cycles after RUN ends -> DRAIN lasts 3 cycles, done the cycle after upd_busy falls.
- Assert rst at RUN cycle 100 -> upd_enable=0 and search_stall=0 the next cycle; entry_valid=0; no done; a new request is accepted afterwards and completes normally.
- upd_busy=1 while IDLE with req_valid=1 -> req_ready=0 until upd_busy=0, then accepted the same cycle.
